trigger_sequencer: RTL and testbench
====================================

Name: trigger_sequencer

Overview:
Consumer end of the matcher event interface. It takes the registered sts_evt outputs of MN trigger matchers and walks a programmable multi-stage sequence; each stage waits for a masked event a programmed number of times. After the last stage it counts a post-trigger delay in sample transfers, then issues a one-cycle trigger pulse to the capture controller. It sits between the matcher bank and the sample-capture/readout logic.

Parameters:
MN, 4, number of matcher event inputs
SNW, 2, stage index width; STAGES = 2**SNW
CW, 16, occurrence/delay counter width

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
cfg_arm  input  1  single-cycle pulse; (re)starts sequence at stage 0
cfg_disarm  input  1  single-cycle pulse; abort to IDLE
cfg_last  input  SNW  index of final stage
cfg_mask  input  STAGES*MN  per-stage event mask; stage k uses bits [k*MN +: MN]
cfg_cnt  input  STAGES*CW  per-stage required hit count; stage k uses [k*CW +: CW]
cfg_delay  input  CW  post-trigger delay in transfers
evt  input  MN  matcher sts_evt vector
sti_transfer  input  1  sample transfer qualifier, shared with matchers
sts_armed  output  1  high in ARMED or DELAY
sts_stage  output  SNW  current stage index
sts_done  output  1  high in DONE
trg  output  1  one-cycle trigger pulse

Behaviour:
- Reset (async): state=IDLE, stage=0, hit counter=0, delay counter=0; all outputs 0.
- All registers clocked on posedge clk; all outputs registered.
- Config inputs sampled live; they must be held stable while armed (no shadowing).
- Hit condition for stage k: sti_transfer & |(evt & mask_k). evt is ignored when sti_transfer=0.
- Effective count: cfg_cnt value 0 is treated as 1.
- States:
  - IDLE: cfg_arm -> ARMED, stage=0, hit counter=0.
  - ARMED: on hit, hit counter +1. When incremented value equals effective count: if stage==cfg_last -> (cfg_delay==0 ? DONE with trg=1 next cycle : DELAY, delay counter=0); else stage+1, hit counter=0. Multiple hits cannot occur in one cycle; one increment max per transfer.
  - DELAY: each sti_transfer increments delay counter; when incremented value equals cfg_delay -> DONE, trg=1 for exactly that one cycle.
  - DONE: hold; sts_done=1; stage holds cfg_last. Leaves only via cfg_arm (-> ARMED) or cfg_disarm (-> IDLE).
- Latency: trg asserts the cycle after the clock edge that sampled the completing transfer (1 cycle).
- Priority per cycle: rst > cfg_disarm > cfg_arm > sequence progress. cfg_arm in any state restarts at stage 0 with counters cleared; the same-cycle hit is discarded.
- cfg_last > STAGES-1 cannot occur (SNW-bit field). cfg_last=0: single-stage sequence.
- Counters are CW bits and never wrap: they compare equal and transition before overflow, since the target is ≤ 2**CW-1.
- Mask of all zeros on the current stage: the sequencer stalls there until arm/disarm.
- sts_armed = (state==ARMED | state==DELAY); sts_stage = current stage register.

Test Plan:
- Reset mid-sequence: arm, reach stage 1, assert rst -> all outputs 0 immediately, state IDLE; subsequent evt ignored until arm.
- Single stage: cfg_last=0, mask0=4'b0001, cnt0=3, delay=0; arm; evt[0] on 3 transfers -> trg one cycle after 3rd transfer; sts_done=1; evt[0] without transfer never counted.
- Three stages: masks 0001/0010/0100, cnt 1/2/1, cfg_last=2 -> sts_stage 0->1->2 at correct transfers; wrong-stage events (evt[2] during stage 0) ignored; trg after stage-2 hit.
- Post-delay: cfg_last=0, cnt0=1, delay=5, transfers gapped with idle cycles -> trg exactly one cycle after 5th transfer following the hit; sts_armed high throughout DELAY.
- Re-arm/disarm: arm then arm again mid-stage-1 -> stage=0, counters cleared; cfg_arm and cfg_disarm same cycle -> IDLE; cfg_arm from DONE restarts sequence.
- Edge counts: cnt0=0 behaves as 1; cnt0=16'hFFFF completes after 65535 hits without wrap; all-zero mask stalls with trg=0.

Source files
------------

// File: rtl/trigger_sequencer_if.sv
// trigger_sequencer_if
// Bundles the configuration, matcher-event and status/trigger signals of the
// trigger sequencer.
//   master : drives configuration, evt and sti_transfer; observes status and trg
//   slave  : the sequencer itself
interface trigger_sequencer_if #(
  parameter int MN  = 4,
  parameter int SNW = 2,
  parameter int CW  = 16
);
  localparam int STAGES = 2 ** SNW;

  logic                  cfg_arm;
  logic                  cfg_disarm;
  logic [SNW-1:0]        cfg_last;
  logic [STAGES*MN-1:0]  cfg_mask;
  logic [STAGES*CW-1:0]  cfg_cnt;
  logic [CW-1:0]         cfg_delay;
  logic [MN-1:0]         evt;
  logic                  sti_transfer;
  logic                  sts_armed;
  logic [SNW-1:0]        sts_stage;
  logic                  sts_done;
  logic                  trg;

  modport master (
    output cfg_arm, cfg_disarm, cfg_last, cfg_mask, cfg_cnt, cfg_delay,
           evt, sti_transfer,
    input  sts_armed, sts_stage, sts_done, trg
  );

  modport slave (
    input  cfg_arm, cfg_disarm, cfg_last, cfg_mask, cfg_cnt, cfg_delay,
           evt, sti_transfer,
    output sts_armed, sts_stage, sts_done, trg
  );
endinterface

// File: rtl/trigger_sequencer.sv
// trigger_sequencer
// Walks a programmable multi-stage trigger sequence driven by matcher events.
// Each stage waits for a masked event on a number of sample transfers; after
// the last stage a post-trigger delay (counted in transfers) runs, then a
// one-cycle trigger pulse is issued to the capture controller.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : trigger_sequencer_if.slave (config, evt/sti_transfer in; status, trg out)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | not armed, events ignored
// ARMED | counting masked hits for the current stage
// DELAY | sequence complete, counting post-trigger transfers
// DONE  | trigger issued, holding until re-arm or disarm
module trigger_sequencer #(
  parameter int MN  = 4,
  parameter int SNW = 2,
  parameter int CW  = 16
) (
  input logic                clk,
  input logic                rst,
  trigger_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DELAY = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state;
  logic [SNW-1:0] stage;
  logic [CW-1:0]  hit_cnt;
  logic [CW-1:0]  dly_cnt;
  logic           armed_q;
  logic           done_q;
  logic           trg_q;

  logic [MN-1:0]  mask_cur;
  logic [CW-1:0]  cnt_cur;
  logic [CW-1:0]  cnt_eff;
  logic [CW-1:0]  hit_nxt;
  logic [CW-1:0]  dly_nxt;
  logic           hit;

  always_comb begin
    mask_cur = bus.cfg_mask[stage*MN +: MN];
    cnt_cur  = bus.cfg_cnt[stage*CW +: CW];
    // A programmed count of zero would never match, so it means "one hit".
    cnt_eff  = (cnt_cur == '0) ? CW'(1) : cnt_cur;
    hit      = bus.sti_transfer & (|(bus.evt & mask_cur));
    hit_nxt  = hit_cnt + CW'(1);
    dly_nxt  = dly_cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      stage   <= '0;
      hit_cnt <= '0;
      dly_cnt <= '0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
      trg_q   <= 1'b0;
    end else begin
      trg_q <= 1'b0;
      if (bus.cfg_disarm) begin
        state   <= IDLE;
        stage   <= '0;
        hit_cnt <= '0;
        dly_cnt <= '0;
        armed_q <= 1'b0;
        done_q  <= 1'b0;
      end else if (bus.cfg_arm) begin
        // Restart from any state; a hit in this same cycle is dropped.
        state   <= ARMED;
        stage   <= '0;
        hit_cnt <= '0;
        dly_cnt <= '0;
        armed_q <= 1'b1;
        done_q  <= 1'b0;
      end else begin
        case (state)
          ARMED: begin
            if (hit) begin
              if (hit_nxt == cnt_eff) begin
                hit_cnt <= '0;
                if (stage == bus.cfg_last) begin
                  if (bus.cfg_delay == '0) begin
                    state   <= DONE;
                    armed_q <= 1'b0;
                    done_q  <= 1'b1;
                    trg_q   <= 1'b1;
                  end else begin
                    state   <= DELAY;
                    dly_cnt <= '0;
                  end
                end else begin
                  stage <= stage + SNW'(1);
                end
              end else begin
                hit_cnt <= hit_nxt;
              end
            end
          end
          DELAY: begin
            if (bus.sti_transfer) begin
              if (dly_nxt == bus.cfg_delay) begin
                state   <= DONE;
                dly_cnt <= '0;
                armed_q <= 1'b0;
                done_q  <= 1'b1;
                trg_q   <= 1'b1;
              end else begin
                dly_cnt <= dly_nxt;
              end
            end
          end
          default: ;  // IDLE and DONE hold until arm/disarm
        endcase
      end
    end
  end

  assign bus.sts_armed = armed_q;
  assign bus.sts_stage = stage;
  assign bus.sts_done  = done_q;
  assign bus.trg       = trg_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
module tb_trigger_sequencer;
  localparam int MN  = 4;
  localparam int SNW = 2;
  localparam int CW  = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  trigger_sequencer_if #(.MN(MN), .SNW(SNW), .CW(CW)) bus ();

  trigger_sequencer #(.MN(MN), .SNW(SNW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic armed, input logic [SNW-1:0] stg,
                         input logic done, input logic t);
    chk({tag, ".armed"}, 32'(bus.sts_armed), 32'(armed));
    chk({tag, ".stage"}, 32'(bus.sts_stage), 32'(stg));
    chk({tag, ".done"},  32'(bus.sts_done),  32'(done));
    chk({tag, ".trg"},   32'(bus.trg),       32'(t));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    bus.cfg_arm = 1'b1;
    tick();
    bus.cfg_arm = 1'b0;
  endtask

  task automatic xfer(input logic [MN-1:0] e);
    bus.evt = e;
    bus.sti_transfer = 1'b1;
    tick();
    bus.sti_transfer = 1'b0;
    bus.evt = '0;
  endtask

  initial begin
    rst = 1'b1;
    bus.cfg_arm = 1'b0;
    bus.cfg_disarm = 1'b0;
    bus.cfg_last = '0;
    bus.cfg_mask = '0;
    bus.cfg_cnt = '0;
    bus.cfg_delay = '0;
    bus.evt = '0;
    bus.sti_transfer = 1'b0;
    tick();
    tick();
    chk_out("reset", 1'b0, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // Single stage, count 3, no delay
    bus.cfg_last = 2'd0;
    bus.cfg_mask = 16'h0001;
    bus.cfg_cnt = {16'd0, 16'd0, 16'd0, 16'd3};
    bus.cfg_delay = 16'd0;
    arm();
    chk_out("single.arm", 1'b1, 2'd0, 1'b0, 1'b0);
    bus.evt = 4'b0001;
    tick();
    tick();
    tick();
    bus.evt = '0;
    xfer(4'b0001);
    xfer(4'b0001);
    chk_out("single.two_hits", 1'b1, 2'd0, 1'b0, 1'b0);
    xfer(4'b0001);
    chk_out("single.trg", 1'b0, 2'd0, 1'b1, 1'b1);
    tick();
    chk_out("single.after", 1'b0, 2'd0, 1'b1, 1'b0);

    // Three stages, masks 0001/0010/0100, counts 1/2/1; arm from DONE
    bus.cfg_last = 2'd2;
    bus.cfg_mask = 16'h0421;
    bus.cfg_cnt = {16'd0, 16'd1, 16'd2, 16'd1};
    arm();
    chk_out("three.arm", 1'b1, 2'd0, 1'b0, 1'b0);
    xfer(4'b0100);
    chk("three.wrong_evt", 32'(bus.sts_stage), 32'd0);
    xfer(4'b0001);
    chk("three.s1", 32'(bus.sts_stage), 32'd1);
    xfer(4'b0010);
    chk("three.s1_half", 32'(bus.sts_stage), 32'd1);
    xfer(4'b0001);
    chk("three.s1_ignore", 32'(bus.sts_stage), 32'd1);
    xfer(4'b0010);
    chk_out("three.s2", 1'b1, 2'd2, 1'b0, 1'b0);
    xfer(4'b0100);
    chk_out("three.trg", 1'b0, 2'd2, 1'b1, 1'b1);

    // Reset mid-sequence
    arm();
    xfer(4'b0001);
    chk("rstmid.s1", 32'(bus.sts_stage), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_out("rstmid.async", 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    xfer(4'b0001);
    xfer(4'b0010);
    xfer(4'b0100);
    chk_out("rstmid.idle", 1'b0, 2'd0, 1'b0, 1'b0);

    // Post-trigger delay of 5 with gapped transfers
    bus.cfg_last = 2'd0;
    bus.cfg_cnt = {16'd0, 16'd0, 16'd0, 16'd1};
    bus.cfg_delay = 16'd5;
    arm();
    xfer(4'b0001);
    chk_out("delay.enter", 1'b1, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      xfer(4'b0000);
    end
    tick();
    tick();
    chk_out("delay.four", 1'b1, 2'd0, 1'b0, 1'b0);
    xfer(4'b0000);
    chk_out("delay.trg", 1'b0, 2'd0, 1'b1, 1'b1);
    tick();
    chk("delay.trg_once", 32'(bus.trg), 32'd0);

    // Re-arm mid-stage-1 clears counters
    bus.cfg_last = 2'd2;
    bus.cfg_cnt = {16'd0, 16'd1, 16'd2, 16'd1};
    bus.cfg_delay = 16'd0;
    arm();
    xfer(4'b0001);
    xfer(4'b0010);
    chk("rearm.s1", 32'(bus.sts_stage), 32'd1);
    arm();
    chk_out("rearm.restart", 1'b1, 2'd0, 1'b0, 1'b0);
    xfer(4'b0001);
    xfer(4'b0010);
    chk("rearm.cleared", 32'(bus.sts_stage), 32'd1);
    // Arm with a same-cycle hit: the hit is discarded
    bus.evt = 4'b0001;
    bus.sti_transfer = 1'b1;
    arm();
    bus.sti_transfer = 1'b0;
    bus.evt = '0;
    chk("rearm.hit_dropped", 32'(bus.sts_stage), 32'd0);
    // Arm and disarm together -> IDLE
    bus.cfg_arm = 1'b1;
    bus.cfg_disarm = 1'b1;
    tick();
    bus.cfg_arm = 1'b0;
    bus.cfg_disarm = 1'b0;
    chk_out("armdis.idle", 1'b0, 2'd0, 1'b0, 1'b0);
    xfer(4'b0001);
    chk_out("armdis.ignored", 1'b0, 2'd0, 1'b0, 1'b0);

    // Count 0 behaves as 1
    bus.cfg_last = 2'd0;
    bus.cfg_cnt = '0;
    arm();
    xfer(4'b0001);
    chk_out("cnt0.trg", 1'b0, 2'd0, 1'b1, 1'b1);

    // All-zero mask stalls
    bus.cfg_mask = 16'h0000;
    bus.cfg_cnt = {16'd0, 16'd0, 16'd0, 16'd1};
    arm();
    for (int i = 0; i < 5; i++) xfer(4'b1111);
    chk_out("mask0.stall", 1'b1, 2'd0, 1'b0, 1'b0);
    bus.cfg_disarm = 1'b1;
    tick();
    bus.cfg_disarm = 1'b0;
    chk_out("mask0.disarm", 1'b0, 2'd0, 1'b0, 1'b0);

    // Maximum count: completes on hit 65535 with no wrap
    bus.cfg_mask = 16'h0001;
    bus.cfg_cnt = {16'd0, 16'd0, 16'd0, 16'hFFFF};
    arm();
    bus.evt = 4'b0001;
    bus.sti_transfer = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk);
    end
    #1;
    chk_out("max.pre", 1'b1, 2'd0, 1'b0, 1'b0);
    tick();
    bus.sti_transfer = 1'b0;
    bus.evt = '0;
    chk_out("max.trg", 1'b0, 2'd0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
